// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register IDs, status codes and
// the values a bubble loads into a pipeline register.
package y86_pkg;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [3:0] {
        S_AOK = 4'h1,
        S_HLT = 4'h2,
        S_ADR = 4'h3,
        S_INS = 4'h4
    } stat_e;

    localparam logic [3:0] BUB_STAT  = S_AOK;
    localparam logic [3:0] BUB_ICODE = I_NOP;
    localparam logic [3:0] BUB_IFUN  = 4'h0;

endpackage

// File: rtl/decode_read_fwd_sel.sv
// Forwarding priority mux: youngest producer of the source register wins,
// falling back to the register-file read value.
module fwd_sel
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [3:0]   i_src,
    input  logic [3:0]   i_e_dste,
    input  logic [W-1:0] i_e_vale,
    input  logic [3:0]   i_m_dstm,
    input  logic [W-1:0] i_m_valm,
    input  logic [3:0]   i_m_dste,
    input  logic [W-1:0] i_m_vale,
    input  logic [3:0]   i_w_dstm,
    input  logic [W-1:0] i_w_valm,
    input  logic [3:0]   i_w_dste,
    input  logic [W-1:0] i_w_vale,
    input  logic [W-1:0] i_rval,
    output logic [W-1:0] o_val
);

    always_comb begin
        o_val = i_rval;
        // RNONE is a "no register" marker, never a real producer match.
        if (i_src != RNONE) begin
            if (i_src == i_e_dste)      o_val = i_e_vale;
            else if (i_src == i_m_dstm) o_val = i_m_valm;
            else if (i_src == i_m_dste) o_val = i_m_vale;
            else if (i_src == i_w_dstm) o_val = i_w_valm;
            else if (i_src == i_w_dste) o_val = i_w_vale;
        end
    end

endmodule

// File: rtl/decode_read.sv
// Y86-64 decode/register-read stage: register ID decode, forwarded operand
// selection, load/use detection and the D->E pipeline register.
module decode_read
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   D_stat,
    input  logic [3:0]   D_icode,
    input  logic [3:0]   D_ifun,
    input  logic [3:0]   D_rA,
    input  logic [3:0]   D_rB,
    input  logic [W-1:0] D_valC,
    input  logic [W-1:0] D_valP,
    output logic [3:0]   d_srcA,
    output logic [3:0]   d_srcB,
    input  logic [W-1:0] rvalA,
    input  logic [W-1:0] rvalB,
    input  logic [3:0]   e_dstE,
    input  logic [W-1:0] e_valE,
    input  logic [3:0]   M_dstM,
    input  logic [W-1:0] m_valM,
    input  logic [3:0]   M_dstE,
    input  logic [W-1:0] M_valE,
    input  logic [3:0]   W_dstM,
    input  logic [W-1:0] W_valM,
    input  logic [3:0]   W_dstE,
    input  logic [W-1:0] W_valE,
    input  logic         E_bubble,
    output logic         load_use,
    output logic [3:0]   E_stat,
    output logic [3:0]   E_icode,
    output logic [3:0]   E_ifun,
    output logic [W-1:0] E_valC,
    output logic [W-1:0] E_valA,
    output logic [W-1:0] E_valB,
    output logic [3:0]   E_dstE,
    output logic [3:0]   E_dstM,
    output logic [3:0]   E_srcA,
    output logic [3:0]   E_srcB
);

    logic [3:0]   w_srcA, w_srcB, w_dstE, w_dstM;
    logic [W-1:0] w_fwdA, w_fwdB, w_valA;

    logic [3:0]   r_E_stat, r_E_icode, r_E_ifun;
    logic [W-1:0] r_E_valC, r_E_valA, r_E_valB;
    logic [3:0]   r_E_dstE, r_E_dstM, r_E_srcA, r_E_srcB;

    // cmovXX writes rB unconditionally here; execute squashes dstE on a false condition.
    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (D_icode)
            I_RRMOVQ: begin w_srcA = D_rA; w_dstE = D_rB; end
            I_IRMOVQ: begin w_dstE = D_rB; end
            I_RMMOVQ: begin w_srcA = D_rA; w_srcB = D_rB; end
            I_MRMOVQ: begin w_srcB = D_rB; w_dstM = D_rA; end
            I_OPQ:    begin w_srcA = D_rA; w_srcB = D_rB; w_dstE = D_rB; end
            I_CALL:   begin w_srcB = RSP;  w_dstE = RSP; end
            I_RET:    begin w_srcA = RSP;  w_srcB = RSP; w_dstE = RSP; end
            I_PUSHQ:  begin w_srcA = D_rA; w_srcB = RSP; w_dstE = RSP; end
            I_POPQ:   begin w_srcA = RSP;  w_srcB = RSP; w_dstE = RSP; w_dstM = D_rA; end
            default:  ;
        endcase
    end

    fwd_sel #(.W(W)) u_fwd_a (
        .i_src(w_srcA),
        .i_e_dste(e_dstE), .i_e_vale(e_valE),
        .i_m_dstm(M_dstM), .i_m_valm(m_valM),
        .i_m_dste(M_dstE), .i_m_vale(M_valE),
        .i_w_dstm(W_dstM), .i_w_valm(W_valM),
        .i_w_dste(W_dstE), .i_w_vale(W_valE),
        .i_rval(rvalA),
        .o_val(w_fwdA)
    );

    fwd_sel #(.W(W)) u_fwd_b (
        .i_src(w_srcB),
        .i_e_dste(e_dstE), .i_e_vale(e_valE),
        .i_m_dstm(M_dstM), .i_m_valm(m_valM),
        .i_m_dste(M_dstE), .i_m_vale(M_valE),
        .i_w_dstm(W_dstM), .i_w_valm(W_valM),
        .i_w_dste(W_dstE), .i_w_vale(W_valE),
        .i_rval(rvalB),
        .o_val(w_fwdB)
    );

    // jXX and call carry the fall-through/return address in valA.
    assign w_valA = (D_icode == I_JXX || D_icode == I_CALL) ? D_valP : w_fwdA;

    always_ff @(posedge clk) begin
        if (rst || E_bubble) begin
            r_E_stat  <= BUB_STAT;
            r_E_icode <= BUB_ICODE;
            r_E_ifun  <= BUB_IFUN;
            r_E_valC  <= '0;
            r_E_valA  <= '0;
            r_E_valB  <= '0;
            r_E_dstE  <= RNONE;
            r_E_dstM  <= RNONE;
            r_E_srcA  <= RNONE;
            r_E_srcB  <= RNONE;
        end else begin
            r_E_stat  <= D_stat;
            r_E_icode <= D_icode;
            r_E_ifun  <= D_ifun;
            r_E_valC  <= D_valC;
            r_E_valA  <= w_valA;
            r_E_valB  <= w_fwdB;
            r_E_dstE  <= w_dstE;
            r_E_dstM  <= w_dstM;
            r_E_srcA  <= w_srcA;
            r_E_srcB  <= w_srcB;
        end
    end

    assign load_use = (r_E_icode == I_MRMOVQ || r_E_icode == I_POPQ) &&
                      (r_E_dstM != RNONE) &&
                      (r_E_dstM == w_srcA || r_E_dstM == w_srcB);

    assign d_srcA  = w_srcA;
    assign d_srcB  = w_srcB;
    assign E_stat  = r_E_stat;
    assign E_icode = r_E_icode;
    assign E_ifun  = r_E_ifun;
    assign E_valC  = r_E_valC;
    assign E_valA  = r_E_valA;
    assign E_valB  = r_E_valB;
    assign E_dstE  = r_E_dstE;
    assign E_dstM  = r_E_dstM;
    assign E_srcA  = r_E_srcA;
    assign E_srcB  = r_E_srcB;

endmodule

// File: tb/tb_decode_read.sv
// Bench for decode_read: directed scenarios followed by random decode traffic,
// all checked against an instruction-level reference model.
module tb_decode_read;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [W-1:0] D_valC, D_valP;
    logic [3:0]   d_srcA, d_srcB;
    logic [W-1:0] rvalA, rvalB;
    logic [3:0]   e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
    logic [W-1:0] e_valE, m_valM, M_valE, W_valM, W_valE;
    logic         E_bubble, load_use;
    logic [3:0]   E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [W-1:0] E_valC, E_valA, E_valB;

    decode_read #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .rvalA(rvalA), .rvalB(rvalB),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_valE(M_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_valE(W_valE),
        .E_bubble(E_bubble), .load_use(load_use),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // model of the E register contents
    logic [3:0]   m_stat, m_icode, m_ifun, m_dste, m_dstm, m_srca, m_srcb;
    logic [W-1:0] m_valc, m_vala, m_valb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_src_a(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_src_b(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_dst_e(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_dst_m(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return 4'hF;
    endfunction

    // producers listed youngest first; first hit wins
    function automatic logic [W-1:0] ref_fwd(input logic [3:0] src, input logic [W-1:0] rv);
        logic [3:0]   d[5];
        logic [W-1:0] v[5];
        d = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        v = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        if (src == 4'hF) return rv;
        for (int i = 0; i < 5; i++)
            if (d[i] == src) return v[i];
        return rv;
    endfunction

    task automatic comb_chk();
        logic [3:0] sa, sb;
        logic       lu;
        #1;
        sa = ref_src_a(D_icode, D_rA);
        sb = ref_src_b(D_icode, D_rB);
        lu = (m_icode inside {4'h5, 4'hB}) && (m_dstm != 4'hF) &&
             (m_dstm == sa || m_dstm == sb);
        chk("d_srcA", d_srcA, sa);
        chk("d_srcB", d_srcB, sb);
        chk("load_use", load_use, lu);
    endtask

    task automatic clk_step();
        logic [3:0] sa, sb;
        sa = ref_src_a(D_icode, D_rA);
        sb = ref_src_b(D_icode, D_rB);
        if (rst || E_bubble) begin
            {m_stat, m_icode, m_ifun} = {4'h1, 4'h1, 4'h0};
            {m_valc, m_vala, m_valb}  = '0;
            {m_dste, m_dstm, m_srca, m_srcb} = 16'hFFFF;
        end else begin
            m_stat = D_stat; m_icode = D_icode; m_ifun = D_ifun; m_valc = D_valC;
            m_vala = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : ref_fwd(sa, rvalA);
            m_valb = ref_fwd(sb, rvalB);
            m_dste = ref_dst_e(D_icode, D_rB);
            m_dstm = ref_dst_m(D_icode, D_rA);
            m_srca = sa;
            m_srcb = sb;
        end
        @(posedge clk);
        #1;
        chk("E_stat", E_stat, m_stat);
        chk("E_icode", E_icode, m_icode);
        chk("E_ifun", E_ifun, m_ifun);
        chk("E_valC", E_valC, m_valc);
        chk("E_valA", E_valA, m_vala);
        chk("E_valB", E_valB, m_valb);
        chk("E_dstE", E_dstE, m_dste);
        chk("E_dstM", E_dstM, m_dstm);
        chk("E_srcA", E_srcA, m_srca);
        chk("E_srcB", E_srcB, m_srcb);
        @(negedge clk);
    endtask

    task automatic clear_fwd();
        {e_dstE, M_dstM, M_dstE, W_dstM, W_dstE} = 20'hFFFFF;
        {e_valE, m_valM, M_valE, W_valM, W_valE} = '0;
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
    endfunction

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1; E_bubble = 1'b0;
        D_stat = 4'h3; D_icode = 4'h6; D_ifun = 4'h2; D_rA = 4'h1; D_rB = 4'h2;
        D_valC = 64'h1234; D_valP = 64'h99;
        rvalA = 64'h5; rvalB = 64'h6;
        clear_fwd();
        m_icode = 4'h1; m_dstm = 4'hF;
        @(negedge clk);

        clk_step();
        chk("rst_icode", E_icode, 4'h1);
        chk("rst_stat", E_stat, 4'h1);
        chk("rst_ids", {E_dstE, E_dstM, E_srcA, E_srcB}, 16'hFFFF);
        chk("rst_valA", E_valA, 64'h0);
        rst = 1'b0;

        D_stat = 4'h1; D_icode = 4'h6; D_ifun = 4'h0; D_rA = 4'h2; D_rB = 4'h3;
        rvalA = 64'h5; rvalB = 64'h7;
        comb_chk();
        chk("opq_srcA", d_srcA, 4'h2);
        chk("opq_srcB", d_srcB, 4'h3);
        clk_step();
        chk("opq_valA", E_valA, 64'h5);
        chk("opq_valB", E_valB, 64'h7);
        chk("opq_dstE", E_dstE, 4'h3);
        chk("opq_dstM", E_dstM, 4'hF);

        e_dstE = 4'h2; e_valE = 64'h11;
        M_dstE = 4'h2; M_valE = 64'h22;
        W_dstE = 4'h2; W_valE = 64'h33;
        clk_step();
        chk("fwd_e", E_valA, 64'h11);
        e_dstE = 4'hF;
        clk_step();
        chk("fwd_M", E_valA, 64'h22);
        M_dstE = 4'hF;
        clk_step();
        chk("fwd_W", E_valA, 64'h33);

        clear_fwd();
        M_dstM = 4'h4; m_valM = 64'hAA; M_dstE = 4'h4; M_valE = 64'h108;
        D_icode = 4'hA; D_rA = 4'h4; D_rB = 4'hF;
        clk_step();
        chk("popq_rsp", E_valA, 64'hAA);

        clear_fwd();
        D_icode = 4'h5; D_rA = 4'h1; D_rB = 4'h2;
        clk_step();
        D_icode = 4'h6; D_rA = 4'h1; D_rB = 4'h2;
        comb_chk();
        chk("lu_hit", load_use, 1'b1);
        D_rA = 4'h5; D_rB = 4'h6;
        comb_chk();
        chk("lu_miss", load_use, 1'b0);
        D_icode = 4'h5; D_rA = 4'hF; D_rB = 4'h2;
        clk_step();
        D_icode = 4'h6; D_rA = 4'hF; D_rB = 4'hF;
        comb_chk();
        chk("lu_rnone", load_use, 1'b0);

        D_icode = 4'h8; D_rA = 4'hF; D_rB = 4'hF; D_valP = 64'h40; rvalB = 64'h200;
        clk_step();
        chk("call_valA", E_valA, 64'h40);
        chk("call_valB", E_valB, 64'h200);
        chk("call_dstE", E_dstE, 4'h4);
        E_bubble = 1'b1;
        clk_step();
        chk("bub_icode", E_icode, 4'h1);
        chk("bub_valA", E_valA, 64'h0);
        E_bubble = 1'b0;

        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 49) == 0);
            E_bubble = ($urandom_range(0, 14) == 0);
            D_stat   = 4'($urandom_range(0, 15));
            D_icode  = 4'($urandom_range(0, 15));
            D_ifun   = 4'($urandom_range(0, 15));
            D_rA = rnd_reg(); D_rB = rnd_reg();
            D_valC = rnd_word(); D_valP = rnd_word();
            rvalA = rnd_word(); rvalB = rnd_word();
            e_dstE = rnd_reg(); M_dstM = rnd_reg(); M_dstE = rnd_reg();
            W_dstM = rnd_reg(); W_dstE = rnd_reg();
            e_valE = rnd_word(); m_valM = rnd_word(); M_valE = rnd_word();
            W_valM = rnd_word(); W_valE = rnd_word();
            comb_chk();
            clk_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_read.md
Name: decode_read

Overview:
- Decode/register-read stage for the pipelined Y86-64 core; the read side of the register file that the write-back stage updates.
- Derives source and destination register IDs from the fetched instruction and drives the register-file read ports.
- Selects valA/valB with full forwarding from the E, M and W stages, detects load/use hazards, and holds the D→E pipeline register with bubble support.

Parameters:
- W, 64, data width of register values and constants
- RNONE, 4'hF, "no register" ID
- RSP, 4'h4, stack-pointer register ID

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- D_stat  in  4  status of the instruction in decode
- D_icode  in  4  instruction code
- D_ifun  in  4  function code
- D_rA  in  4  register field A
- D_rB  in  4  register field B
- D_valC  in  W  constant word
- D_valP  in  W  incremented PC
- d_srcA  out  4  register-file read address A (combinational)
- d_srcB  out  4  register-file read address B (combinational)
- rvalA  in  W  register-file read data A (combinational read of d_srcA)
- rvalB  in  W  register-file read data B
- e_dstE, e_valE  in  4, W  execute-stage ALU result
- M_dstM, m_valM  in  4, W  memory-stage load result
- M_dstE, M_valE  in  4, W  memory-stage ALU result
- W_dstM, W_valM  in  4, W  write-back load result
- W_dstE, W_valE  in  4, W  write-back ALU result
- E_bubble  in  1  load a nop into the E register this cycle
- load_use  out  1  load/use hazard flag (combinational)
- E_stat, E_icode, E_ifun  out  4 each  registered
- E_valC, E_valA, E_valB  out  W each  registered
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered

Behaviour:
- Opcodes: halt 0, nop 1, rrmovq/cmovXX 2, irmovq 3, rmmovq 4, mrmovq 5, OPq 6, jXX 7, call 8, ret 9, pushq A, popq B.
- d_srcA:
  - D_rA for icode 2, 4, 6, A
  - RSP for icode 9, B
  - RNONE otherwise
- d_srcB:
  - D_rB for icode 4, 5, 6
  - RSP for icode 8, 9, A, B
  - RNONE otherwise
- d_dstE:
  - D_rB for icode 2, 3, 6
  - RSP for icode 8, 9, A, B
  - RNONE otherwise
  - cmov condition is resolved in execute, not here.
- d_dstM: D_rA for icode 5, B; RNONE otherwise.
- d_valA, first match wins:
  1. D_valP if icode is 7 or 8
  2. e_valE if d_srcA==e_dstE
  3. m_valM if d_srcA==M_dstM
  4. M_valE if d_srcA==M_dstE
  5. W_valM if d_srcA==W_dstM
  6. W_valE if d_srcA==W_dstE
  7. rvalA otherwise
- d_valB: same priority chain keyed on d_srcB, without the valP rule.
- RNONE never matches a forwarding source: a source of RNONE yields rvalA/rvalB.
- When several stages target the same register, the youngest wins (e before M before W). Within M, valM beats valE, which covers popq %rsp.
- load_use = (E_icode ∈ {5, B}) && E_dstM≠RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
  - Computed from registered E outputs and current decode fields.
  - Output only; stall/bubble control lives outside this block.
- E register, rising edge:
  - rst=1 or E_bubble=1 → bubble: E_stat=1 (AOK), E_icode=1, E_ifun=0, E_valC=E_valA=E_valB=0, all four reg IDs=RNONE.
  - Otherwise load D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB.
  - rst has priority over E_bubble; the result is identical.
- Reset values: all E outputs hold the bubble values above. d_srcA, d_srcB and load_use follow their inputs combinationally.
- Latency: decode fields appear on E outputs one cycle after being presented.
- An undefined icode passes through with all reg IDs RNONE; E_stat is carried unchanged.

Decomposition:
- y86_pkg holds the icode constants, RNONE, RSP, the status codes (AOK 1, HLT 2, ADR 3, INS 4) and the bubble defaults.
- One sub-module, fwd_sel: a forwarding priority mux taking src, the five dst/val pairs and the regfile value. It is instantiated twice (A and B); the valP override stays in decode_read.

Test Plan:
- Reset: rst high 1 cycle → E_icode=1, E_stat=1, E_dstE=E_dstM=E_srcA=E_srcB=F, E_valA=0.
- OPq (icode 6) rA=2, rB=3, rvalA=5, rvalB=7, no forwarding → d_srcA=2, d_srcB=3; next cycle E_valA=5, E_valB=7, E_dstE=3, E_dstM=F.
- Forward priority: d_srcA=2 with e_dstE=2/e_valE=0x11, M_dstE=2/M_valE=0x22, W_dstE=2/W_valE=0x33 → E_valA=0x11. Clear e_dstE → 0x22. Also clear M_dstE → 0x33.
- popq (icode B) rA=4 in M: M_dstM=4/m_valM=0xAA, M_dstE=4/M_valE=0x108; decode pushq rA=4 → E_valA=0xAA.
- Load/use: E holds mrmovq with E_dstM=1; decode OPq rA=1 → load_use=1. Change rA=5, rB=6 → load_use=0. E_dstM=F → 0.
- call (icode 8) D_valP=0x40, rvalB=0x200 → E_valA=0x40, E_valB=0x200, E_dstE=4. Assert E_bubble the same cycle → E_icode=1, E_valA=0.
